vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Pixel-timing generator and output stage for the VGA path. It produces the pixel coordinates that the region and colour logic decodes into visibility flags. It registers the resulting 24-bit colour together with HSYNC, VSYNC and blanking, so the DAC receives colour and syncs aligned to the same pixel. Default mode is 640x480 @ 60 Hz: 25 MHz pixel rate derived from a 50 MHz system clock.

## Interface
Parameters (default, meaning):
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, HSYNC width in pixels
- H_BP, 48, horizontal back porch in pixels
- V_VIS, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, VSYNC width in lines
- V_BP, 33, vertical back porch in lines

Ports (name, direction, width, meaning):
- clk, in, 1, 50 MHz system clock
- rst_n, in, 1, asynchronous active-low reset
- rgb_in, in, 24, colour for the current (x,y), {r,g,b}, combinational from the region/colour logic
- x, out, 10, current horizontal counter, 0..H_TOTAL-1
- y, out, 10, current vertical counter, 0..V_TOTAL-1
- pix_en, out, 1, one-clk strobe at pixel rate
- frame_start, out, 1, one-clk pulse when the counters wrap to (0,0)
- vga_clk, out, 1, pixel clock to the DAC
- r, g, b, out, 8 each, registered colour
- hsync_n, vsync_n, out, 1 each, active-low syncs
- blank_n, out, 1, low outside the visible area
- sync_n, out, 1, tied 0 (no sync-on-green)

## Operation
- pix_en toggles every clk: 0 after reset, 1 on the first edge, then alternates.
- vga_clk equals the registered inverse of pix_en, so its rising edge falls mid-pixel.
- H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (800 by default).
- V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (525 by default).
- Horizontal counter:
  - Increments on every clk edge where pix_en=1.
  - Wraps H_TOTAL-1 to 0.
- Vertical counter:
  - Increments only on the edge where the horizontal counter wraps.
  - Wraps V_TOTAL-1 to 0.
- Simultaneous wrap of both counters: both become 0 and frame_start pulses for that single clk.
- Decode of counter value (h,v):
  - visible = (h < H_VIS) && (v < V_VIS)
  - hs = h in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] (656..751)
  - vs = v in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1] (490..491)
- Output stage, updated on each pix_en edge from the pre-increment counter value:
  - hsync_n <= ~hs
  - vsync_n <= ~vs
  - blank_n <= visible
  - {r,g,b} <= visible ? rgb_in : 0
- Colour is never driven during blanking, whatever rgb_in holds.
- x and y come straight from the counter registers; downstream decode is combinational.
- Counter widths are fixed at 10 bits. Parameters must satisfy H_TOTAL <= 1024 and V_TOTAL <= 1024.

## Timing
- Reset values (immediate on rst_n low, asynchronous):
  - Counters, x, y = 0.
  - pix_en = 0, vga_clk = 0, frame_start = 0.
  - hsync_n = 1, vsync_n = 1, blank_n = 0.
  - r, g, b = 0, sync_n = 0.
- Latency: outputs for pixel (h,v) appear on the same clk edge that advances the counter past h. That is one pixel (2 clk) after x,y first present h.
- rgb_in must settle within one clk of the x,y change.
- Line period is 1600 clk. Frame period is 840000 clk.
- Reset mid-frame: everything returns to reset values at once. After release, the first pix_en=1 edge restarts at (0,0).
- No partial-line output and no frame_start pulse on the first frame after reset. frame_start fires only on a wrap.

## Structure
- Package vga_pkg holds:
  - Default timing localparams.
  - The derived H_TOTAL / V_TOTAL expressions.
  - A typedef for the 10-bit coordinate.
  - A typedef for the 24-bit rgb struct {r,g,b}.
- One sub-module, mod_counter: a parameterised modulo-N counter with enable input and wrap output.
  - Instantiated twice, horizontal and vertical.
  - The horizontal wrap feeds the vertical enable.

## Test plan
- Reset values: assert rst_n low mid-line -> all outputs match the reset values with no clock edge. Release -> x=0, y=0 and pix_en=1 on the first edge.
- Horizontal timing: run 2 lines -> hsync_n low for exactly 96 pixels (192 clk), falling after output pixel 655. Line period is 1600 clk.
- Vertical timing and frame pulse: run 1 full frame ->
  - vsync_n low for lines 490..491 (3200 clk).
  - frame_start pulses once, 840000 clk after the first (0,0).
- Blanking gate: rgb_in = 24'hFF00FF held constant ->
  - r=FF, g=00, b=FF only while blank_n=1.
  - 0 at h=640..799 and on lines 480..524.
- Alignment: rgb_in = {x[7:0], y[7:0], 8'h5A} ->
  - At the output pixel where x=10, y=3: r=0x0A, g=0x03, b=0x5A.
  - That output occurs exactly 2 clk after x=10 was presented.
- Wrap corner: observe h=799, v=524 -> the next pix_en edge gives x=0 and y=0 together, with frame_start=1 for one clk.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and types.
// The defaults give 640x480 @ 60 Hz at a 25 MHz pixel rate from a 50 MHz clk.
package vga_pkg;

    localparam int unsigned COORD_W = 10;

    localparam int unsigned H_VIS_DEF  = 640;
    localparam int unsigned H_FP_DEF   = 16;
    localparam int unsigned H_SYNC_DEF = 96;
    localparam int unsigned H_BP_DEF   = 48;
    localparam int unsigned V_VIS_DEF  = 480;
    localparam int unsigned V_FP_DEF   = 10;
    localparam int unsigned V_SYNC_DEF = 2;
    localparam int unsigned V_BP_DEF   = 33;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic int unsigned period_total(input int unsigned vis, input int unsigned fp,
                                                 input int unsigned sync, input int unsigned bp);
        return vis + fp + sync + bp;
    endfunction

    localparam int unsigned H_TOTAL_DEF = period_total(H_VIS_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int unsigned V_TOTAL_DEF = period_total(V_VIS_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with enable; wrap is high on the enabled cycle that returns to 0.
module mod_counter
    import vga_pkg::*;
#(
    parameter int unsigned N = H_TOTAL_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic [COORD_W-1:0] count,
    output logic               wrap
);

    localparam coord_t LAST = coord_t'(N - 1);

    assign wrap = en && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel-timing generator and registered output stage.
// Colour, syncs and blanking for pixel (h,v) all update on the edge that advances past h.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VIS  = H_VIS_DEF,
    parameter int unsigned H_FP   = H_FP_DEF,
    parameter int unsigned H_SYNC = H_SYNC_DEF,
    parameter int unsigned H_BP   = H_BP_DEF,
    parameter int unsigned V_VIS  = V_VIS_DEF,
    parameter int unsigned V_FP   = V_FP_DEF,
    parameter int unsigned V_SYNC = V_SYNC_DEF,
    parameter int unsigned V_BP   = V_BP_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] rgb_in,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        pix_en,
    output logic        frame_start,
    output logic        vga_clk,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        blank_n,
    output logic        sync_n
);

    // Both totals must fit the 10-bit counters (<= 1024).
    localparam int unsigned H_TOTAL = period_total(H_VIS, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = period_total(V_VIS, V_FP, V_SYNC, V_BP);

    localparam coord_t H_VIS_C    = coord_t'(H_VIS);
    localparam coord_t V_VIS_C    = coord_t'(V_VIS);
    localparam coord_t HS_FIRST_C = coord_t'(H_VIS + H_FP);
    localparam coord_t HS_LAST_C  = coord_t'(H_VIS + H_FP + H_SYNC - 1);
    localparam coord_t VS_FIRST_C = coord_t'(V_VIS + V_FP);
    localparam coord_t VS_LAST_C  = coord_t'(V_VIS + V_FP + V_SYNC - 1);

    coord_t h;
    coord_t v;
    logic   h_wrap;
    logic   v_wrap;
    logic   visible;
    logic   hs;
    logic   vs;
    rgb_t   rgb_px;
    rgb_t   rgb_q;

    mod_counter #(.N(H_TOTAL)) u_hcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_en),
        .count (h),
        .wrap  (h_wrap)
    );

    mod_counter #(.N(V_TOTAL)) u_vcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (h_wrap),
        .count (v),
        .wrap  (v_wrap)
    );

    assign visible = (h < H_VIS_C) && (v < V_VIS_C);
    assign hs      = (h >= HS_FIRST_C) && (h <= HS_LAST_C);
    assign vs      = (v >= VS_FIRST_C) && (v <= VS_LAST_C);
    assign rgb_px  = rgb_t'(rgb_in);

    // v_wrap already implies pix_en and h_wrap, so it marks the (0,0) return exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_en      <= 1'b0;
            vga_clk     <= 1'b0;
            frame_start <= 1'b0;
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            blank_n     <= 1'b0;
            rgb_q       <= '0;
        end else begin
            pix_en      <= ~pix_en;
            vga_clk     <= ~pix_en;
            frame_start <= v_wrap;
            if (pix_en) begin
                hsync_n <= ~hs;
                vsync_n <= ~vs;
                blank_n <= visible;
                rgb_q   <= visible ? rgb_px : '0;
            end
        end
    end

    assign x      = h;
    assign y      = v;
    assign r      = rgb_q.r;
    assign g      = rgb_q.g;
    assign b      = rgb_q.b;
    assign sync_n = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a reduced-size instance (25x10 total) for frame-level
// vectors and a default 640x480 instance for line timing.
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] rgb_in;
    logic        rgb_mode;
    logic [9:0]  x, y;
    logic        pix_en, frame_start, vga_clk, hsync_n, vsync_n, blank_n, sync_n;
    logic [7:0]  r, g, b;

    logic [23:0] d_rgb;
    logic [9:0]  d_x, d_y;
    logic        d_pix_en, d_frame_start, d_vga_clk, d_hsync_n, d_vsync_n, d_blank_n, d_sync_n;
    logic [7:0]  d_r, d_g, d_b;

    always #5 clk = ~clk;

    // Small mode: H 16/2/4/3 (total 25, hs at 18..21), V 6/1/2/1 (total 10, vs at 7..8).
    vga_timing_gen #(
        .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_VIS(6),  .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in), .x(x), .y(y), .pix_en(pix_en),
        .frame_start(frame_start), .vga_clk(vga_clk), .r(r), .g(g), .b(b),
        .hsync_n(hsync_n), .vsync_n(vsync_n), .blank_n(blank_n), .sync_n(sync_n)
    );

    vga_timing_gen dut_def (
        .clk(clk), .rst_n(rst_n), .rgb_in(d_rgb), .x(d_x), .y(d_y), .pix_en(d_pix_en),
        .frame_start(d_frame_start), .vga_clk(d_vga_clk), .r(d_r), .g(d_g), .b(d_b),
        .hsync_n(d_hsync_n), .vsync_n(d_vsync_n), .blank_n(d_blank_n), .sync_n(d_sync_n)
    );

    always_comb rgb_in = rgb_mode ? 24'hFF00FF : {x[7:0], y[7:0], 8'h5A};

    typedef struct {
        int          k;
        int          ex;
        int          ey;
        logic        pe;
        logic        hs_n;
        logic        vs_n;
        logic        bl_n;
        logic [23:0] rgb;
        logic        fs;
    } vec_t;

    vec_t tbl[$];
    int   checks;
    int   failures;
    int   k;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_x"}, 32'(x), 0);
        chk({tag, "_y"}, 32'(y), 0);
        chk({tag, "_pix_en"}, 32'(pix_en), 0);
        chk({tag, "_vga_clk"}, 32'(vga_clk), 0);
        chk({tag, "_frame_start"}, 32'(frame_start), 0);
        chk({tag, "_hsync_n"}, 32'(hsync_n), 1);
        chk({tag, "_vsync_n"}, 32'(vsync_n), 1);
        chk({tag, "_blank_n"}, 32'(blank_n), 0);
        chk({tag, "_rgb"}, 32'({r, g, b}), 0);
        chk({tag, "_sync_n"}, 32'(sync_n), 0);
        chk({tag, "_def_x"}, 32'(d_x), 0);
        chk({tag, "_def_hsync_n"}, 32'(d_hsync_n), 1);
    endtask

    initial begin
        int idx, fs_k, fs_cnt, vis, bad, n;
        int fall1, fall2, rise1, x_at_fall, vs_low;
        logic prev_hs;

        checks   = 0;
        failures = 0;
        rgb_mode = 1'b0;
        d_rgb    = 24'h123456;
        rst_n    = 1'b0;

        // {k, x, y, pix_en, hsync_n, vsync_n, blank_n, rgb, frame_start} after clk edge k
        tbl.push_back('{1,   0,  0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0});
        tbl.push_back('{2,   1,  0, 1'b0, 1'b1, 1'b1, 1'b1, 24'h00005A, 1'b0});
        tbl.push_back('{22,  11, 0, 1'b0, 1'b1, 1'b1, 1'b1, 24'h0A005A, 1'b0});
        tbl.push_back('{32,  16, 0, 1'b0, 1'b1, 1'b1, 1'b1, 24'h0F005A, 1'b0});
        tbl.push_back('{34,  17, 0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0});
        tbl.push_back('{36,  18, 0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0});
        tbl.push_back('{38,  19, 0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b0});
        tbl.push_back('{44,  22, 0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b0});
        tbl.push_back('{46,  23, 0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0});
        tbl.push_back('{50,  0,  1, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0});
        tbl.push_back('{170, 10, 3, 1'b0, 1'b1, 1'b1, 1'b1, 24'h09035A, 1'b0});
        tbl.push_back('{171, 10, 3, 1'b1, 1'b1, 1'b1, 1'b1, 24'h09035A, 1'b0});
        tbl.push_back('{172, 11, 3, 1'b0, 1'b1, 1'b1, 1'b1, 24'h0A035A, 1'b0});
        tbl.push_back('{302, 1,  6, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0});
        tbl.push_back('{350, 0,  7, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0});
        tbl.push_back('{352, 1,  7, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0});
        tbl.push_back('{450, 0,  9, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0});
        tbl.push_back('{452, 1,  9, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0});
        tbl.push_back('{498, 24, 9, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0});
        tbl.push_back('{499, 24, 9, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0});
        tbl.push_back('{500, 0,  0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b1});
        tbl.push_back('{501, 0,  0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0});
        tbl.push_back('{502, 1,  0, 1'b0, 1'b1, 1'b1, 1'b1, 24'h00005A, 1'b0});

        repeat (3) @(posedge clk);
        #1;
        check_reset("por");

        @(negedge clk);
        rst_n  = 1'b1;
        k      = 0;
        idx    = 0;
        fs_k   = -1;
        fs_cnt = 0;
        while (k < 502) begin
            step();
            if (frame_start === 1'b1) begin
                fs_cnt++;
                if (fs_k < 0) fs_k = k;
            end
            if (idx < tbl.size() && tbl[idx].k == k) begin
                chk($sformatf("k%0d_x", k), 32'(x), 32'(tbl[idx].ex));
                chk($sformatf("k%0d_y", k), 32'(y), 32'(tbl[idx].ey));
                chk($sformatf("k%0d_pix_en", k), 32'(pix_en), 32'(tbl[idx].pe));
                chk($sformatf("k%0d_vga_clk", k), 32'(vga_clk), 32'(tbl[idx].pe));
                chk($sformatf("k%0d_hsync_n", k), 32'(hsync_n), 32'(tbl[idx].hs_n));
                chk($sformatf("k%0d_vsync_n", k), 32'(vsync_n), 32'(tbl[idx].vs_n));
                chk($sformatf("k%0d_blank_n", k), 32'(blank_n), 32'(tbl[idx].bl_n));
                chk($sformatf("k%0d_rgb", k), 32'({r, g, b}), 32'(tbl[idx].rgb));
                chk($sformatf("k%0d_frame_start", k), 32'(frame_start), 32'(tbl[idx].fs));
                idx++;
            end
        end
        chk("first_frame_start_k", 32'(fs_k), 32'd500);
        chk("frame1_start_count", 32'(fs_cnt), 32'd1);

        // Constant colour for one full frame: colour only where blank_n is high.
        rgb_mode = 1'b1;
        fs_k     = -1;
        fs_cnt   = 0;
        vis      = 0;
        bad      = 0;
        while (k < 1004) begin
            step();
            if (k >= 505) begin
                if (blank_n === 1'b1) vis++;
                if ({r, g, b} !== (blank_n === 1'b1 ? 24'hFF00FF : 24'h000000)) bad++;
                if (frame_start === 1'b1) begin
                    fs_cnt++;
                    if (fs_k < 0) fs_k = k;
                end
            end
        end
        chk("gate_bad_samples", 32'(bad), 32'd0);
        chk("gate_visible_clks", 32'(vis), 32'd192);
        chk("frame2_start_count", 32'(fs_cnt), 32'd1);
        chk("frame2_start_k", 32'(fs_k), 32'd1000);

        // Asynchronous reset in the middle of a line.
        n = 0;
        while (x !== 10'd5 && n < 200) begin
            step();
            n++;
        end
        chk("mid_line_x_found", 32'(x), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("mid");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        step();
        chk("rel_x", 32'(x), 0);
        chk("rel_y", 32'(y), 0);
        chk("rel_pix_en", 32'(pix_en), 1);
        chk("rel_def_x", 32'(d_x), 0);
        chk("rel_def_pix_en", 32'(d_pix_en), 1);

        // Default 640x480 line timing over two lines.
        fall1     = -1;
        fall2     = -1;
        rise1     = -1;
        x_at_fall = -1;
        vs_low    = 0;
        fs_k      = -1;
        prev_hs   = d_hsync_n;
        while (k < 3000) begin
            step();
            if (prev_hs === 1'b1 && d_hsync_n === 1'b0) begin
                if (fall1 < 0) begin
                    fall1     = k;
                    x_at_fall = int'(d_x);
                end else if (fall2 < 0) begin
                    fall2 = k;
                end
            end
            if (prev_hs === 1'b0 && d_hsync_n === 1'b1 && rise1 < 0) rise1 = k;
            prev_hs = d_hsync_n;
            if (d_vsync_n !== 1'b1) vs_low++;
            if (frame_start === 1'b1 && fs_k < 0) fs_k = k;
        end
        chk("def_hsync_fall_k", 32'(fall1), 32'd1314);
        chk("def_hsync_fall_x", 32'(x_at_fall), 32'd657);
        chk("def_hsync_low_clks", 32'(rise1 - fall1), 32'd192);
        chk("def_line_period", 32'(fall2 - fall1), 32'd1600);
        chk("def_vsync_low_clks", 32'(vs_low), 32'd0);
        chk("post_reset_first_fs_k", 32'(fs_k), 32'd500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
